reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter BYPASS, default 1, meaning: a same-cycle write-back is forwarded to the read ports.
REQ-002 SHALL have clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have rd_a_id, rd_b_id  input  8 (reg_id_t)  read-port register ids.
REQ-005 SHALL have rd_a_val, rd_b_val  output  70 (reg_val_t)  read values, combinational.
REQ-006 SHALL have rd_a_ready, rd_b_ready  output  1  operand valid; not busy, or bypassed.
REQ-007 SHALL have pc_val, imm_val  input  64  sources for rip and rimm reads.
REQ-008 SHALL have rsv_valid  input  1; rsv_id  input  8; rsv_ready  output  1  destination reservation handshake.
REQ-009 SHALL have wb_valid  input  1; wb_id  input  8; wb_val  input  70  write-back port.
REQ-010 SHALL have flush  input  1  clears all reservations.
REQ-011 SHALL have dump_req  input  1; dump_valid  output  1; dump_ready  input  1; dump_idx  output  5; dump_val  output  70  register dump stream.
REQ-012 SHALL have err  output  1  sticky protocol-error flag.

Function
REQ-013 SHALL hold REG_FILE_SIZE (20) entries of reg_val_t, indexed by the low 7 bits of a real reg_id_t (rax..rhc).
REQ-014 Fake reads SHALL return ready=1 and: rnil/rsyscall -> all 0; rv0 -> val 0; rv8 -> val 8; rip -> val pc_val; rimm -> val imm_val; flags 0 in every case.
REQ-015 A real-register read SHALL return the stored entry, ready = !busy[idx]; if BYPASS=1 and wb_valid && wb_id==rd_id, it SHALL return wb_val with ready=1.
REQ-016 rsv_ready SHALL be 1 when rsv_id is fake, or when busy[idx]==0, or when a same-cycle write-back clears idx; otherwise 0 (WAW stall).
REQ-017 Reservation of a real register SHALL be accepted on rsv_valid && rsv_ready and set busy[idx] at the next edge; fake ids SHALL be accepted with no state change.
REQ-018 Write-back of a real register SHALL write wb_val and clear busy[idx] at the next edge; the new value is visible to non-bypassed reads one cycle later.
REQ-019 When write-back and reservation target the same idx in the same cycle, busy SHALL end at 1 and the value SHALL be wb_val.
REQ-020 A write-back to a fake id, or to a real id with busy==0, SHALL set err and SHALL NOT modify state.
REQ-021 flush SHALL clear all busy bits at the next edge, overriding same-cycle reservations; a same-cycle write-back SHALL still update its value.
REQ-022 The dump FSM SHALL have states IDLE, STREAM and DONE: IDLE->STREAM on dump_req; in STREAM, dump_valid=1 and each dump_valid&&dump_ready beat advances dump_idx 0..19; after beat 19, STREAM->DONE; DONE->IDLE after one cycle.
REQ-023 dump_val SHALL reflect the current array contents at the handshake cycle, and SHALL NOT be bypassed; dump_req while not IDLE SHALL be ignored.
REQ-024 The dump SHALL NOT stall reads, reservations or write-backs.

Reset
REQ-025 While reset is asserted, all 20 entries SHALL be 0, all busy bits 0, err 0, FSM in IDLE, dump_valid 0 and dump_idx 0.
REQ-026 Reset asserted during STREAM SHALL abort the dump immediately, with no further beats.

Structure
REQ-027 reg_id_t, reg_val_t, REG_FILE_SIZE, reg_in_file and reg_num SHALL come from the shared RegMap package; the dump FSM state enum SHALL be local.
REQ-028 The scoreboard (busy bits, rsv_ready, flush) SHALL be one sub-module named reg_scoreboard.

Verification
REQ-029 Reset, then read rax and rv8 -> rax val 0 ready 1; rv8 val 8 ready 1.
REQ-030 Reserve rcx, then read rcx -> ready 0; next cycle wb rcx=0x1234 -> same-cycle read ready 1 val 0x1234; next cycle rsv_ready for rcx =1.
REQ-031 Reserve rdx twice in consecutive cycles -> second rsv_ready=0 until rdx write-back, then accepted.
REQ-032 wb rbx with rbx not busy, and wb rimm -> err=1, rbx stays 0.
REQ-033 Write r8=0xAA, dump_req, dump_ready toggled 1/0 -> 20 beats idx 0..19, idx 8 val 0xAA, FSM returns to IDLE.
REQ-034 Reserve rsi, rdi; flush with a same-cycle reserve of r9 -> rsi, rdi and r9 all ready next cycle.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// Shared register-map definitions: register ids, register value layout and
// helpers that map a register id onto a physical register-file slot.
package RegMap;

  localparam int REG_FILE_SIZE = 20;
  localparam int REG_IDX_W     = 5;

  // Ids with bit 7 clear are architectural registers stored in the file;
  // ids with bit 7 set are synthesised on read and never stored.
  typedef enum logic [7:0] {
    rax      = 8'h00,
    rcx      = 8'h01,
    rdx      = 8'h02,
    rbx      = 8'h03,
    rsp      = 8'h04,
    rbp      = 8'h05,
    rsi      = 8'h06,
    rdi      = 8'h07,
    r8       = 8'h08,
    r9       = 8'h09,
    r10      = 8'h0a,
    r11      = 8'h0b,
    r12      = 8'h0c,
    r13      = 8'h0d,
    r14      = 8'h0e,
    r15      = 8'h0f,
    rgs      = 8'h10,
    rha      = 8'h11,
    rhb      = 8'h12,
    rhc      = 8'h13,
    rnil     = 8'h80,
    rsyscall = 8'h81,
    rv0      = 8'h82,
    rv8      = 8'h83,
    rip      = 8'h84,
    rimm     = 8'h85
  } reg_id_t;

  typedef struct packed {
    logic [5:0]  flags;
    logic [63:0] val;
  } reg_val_t;

  function automatic logic reg_in_file(input reg_id_t id);
    return (id[7] == 1'b0) && (id[6:0] < 7'(REG_FILE_SIZE));
  endfunction

  // Only meaningful when reg_in_file(id) holds; every real slot fits in 5 bits.
  function automatic logic [REG_IDX_W-1:0] reg_num(input reg_id_t id);
    return id[REG_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Busy-bit scoreboard: tracks outstanding destination reservations, decides
// whether a new reservation may proceed and whether a write-back is legal.
module reg_scoreboard
  import RegMap::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rsv_valid_i,
  input  reg_id_t                  rsv_id_i,
  output logic                     rsv_ready_o,
  input  logic                     wb_valid_i,
  input  reg_id_t                  wb_id_i,
  output logic                     wb_legal_o,
  output logic                     wb_err_o,
  input  logic                     flush_i,
  output logic [REG_FILE_SIZE-1:0] busy_o
);

  logic [REG_FILE_SIZE-1:0] busy_q;
  logic [REG_FILE_SIZE-1:0] busy_d;
  logic                     wb_real;
  logic                     rsv_real;
  logic [REG_IDX_W-1:0]     wb_idx;
  logic [REG_IDX_W-1:0]     rsv_idx;

  assign wb_real  = reg_in_file(wb_id_i);
  assign rsv_real = reg_in_file(rsv_id_i);
  assign wb_idx   = reg_num(wb_id_i);
  assign rsv_idx  = reg_num(rsv_id_i);

  // Only a write-back that retires an outstanding reservation is legal.
  assign wb_legal_o = wb_valid_i && wb_real && busy_q[wb_idx];
  assign wb_err_o   = wb_valid_i && !wb_legal_o;

  assign rsv_ready_o = !rsv_real || !busy_q[rsv_idx] ||
                       (wb_legal_o && (wb_idx == rsv_idx));

  genvar gi;
  generate
    for (gi = 0; gi < REG_FILE_SIZE; gi++) begin : g_busy
      logic set_hit;
      logic clr_hit;
      assign clr_hit = wb_legal_o && (wb_idx == REG_IDX_W'(gi));
      assign set_hit = rsv_valid_i && rsv_ready_o && rsv_real &&
                       (rsv_idx == REG_IDX_W'(gi));
      // New reservation beats a same-cycle retire; flush beats both.
      assign busy_d[gi] = !flush_i && (set_hit || (busy_q[gi] && !clr_hit));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with busy-bit scoreboard, two combinational read ports with
// optional write-back forwarding, and a back-pressured register dump stream.
module reg_file_sb
  import RegMap::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  reg_id_t        rd_a_id,
  input  reg_id_t        rd_b_id,
  output reg_val_t       rd_a_val,
  output reg_val_t       rd_b_val,
  output logic           rd_a_ready,
  output logic           rd_b_ready,
  input  logic [63:0]    pc_val,
  input  logic [63:0]    imm_val,
  input  logic           rsv_valid,
  input  reg_id_t        rsv_id,
  output logic           rsv_ready,
  input  logic           wb_valid,
  input  reg_id_t        wb_id,
  input  reg_val_t       wb_val,
  input  logic           flush,
  input  logic           dump_req,
  output logic           dump_valid,
  input  logic           dump_ready,
  output logic [4:0]     dump_idx,
  output reg_val_t       dump_val,
  output logic           err
);

  typedef enum logic [1:0] {
    DUMP_IDLE,
    DUMP_STREAM,
    DUMP_DONE
  } dump_state_e;

  reg_val_t                 regs_q [REG_FILE_SIZE];
  reg_val_t                 regs_d [REG_FILE_SIZE];
  logic [REG_FILE_SIZE-1:0] busy;
  logic                     wb_legal;
  logic                     wb_err;
  logic [REG_IDX_W-1:0]     wb_idx;
  logic                     err_q;
  dump_state_e              state_q;
  dump_state_e              state_d;
  logic [REG_IDX_W-1:0]     idx_q;
  logic [REG_IDX_W-1:0]     idx_d;

  reg_scoreboard u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .rsv_valid_i (rsv_valid),
    .rsv_id_i    (rsv_id),
    .rsv_ready_o (rsv_ready),
    .wb_valid_i  (wb_valid),
    .wb_id_i     (wb_id),
    .wb_legal_o  (wb_legal),
    .wb_err_o    (wb_err),
    .flush_i     (flush),
    .busy_o      (busy)
  );

  assign wb_idx = reg_num(wb_id);

  genvar gi;
  generate
    for (gi = 0; gi < REG_FILE_SIZE; gi++) begin : g_entry
      assign regs_d[gi] = (wb_legal && (wb_idx == REG_IDX_W'(gi))) ? wb_val : regs_q[gi];
    end

    for (gi = 0; gi < 2; gi++) begin : g_rd
      reg_id_t  id;
      reg_val_t val;
      logic     rdy;
      assign id = (gi == 0) ? rd_a_id : rd_b_id;
      always_comb begin
        val = '0;
        rdy = 1'b1;
        if (reg_in_file(id)) begin
          if (BYPASS && wb_valid && (wb_id == id)) begin
            val = wb_val;
          end else begin
            val = regs_q[reg_num(id)];
            rdy = !busy[reg_num(id)];
          end
        end else begin
          case (id)
            rv8:     val.val = 64'd8;
            rip:     val.val = pc_val;
            rimm:    val.val = imm_val;
            default: val.val = 64'd0;
          endcase
        end
      end
    end
  endgenerate

  assign rd_a_val   = g_rd[0].val;
  assign rd_a_ready = g_rd[0].rdy;
  assign rd_b_val   = g_rd[1].val;
  assign rd_b_ready = g_rd[1].rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_FILE_SIZE; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Dump stream walks the slots in order; it only observes the array, so the
  // pipeline keeps reading, reserving and retiring while it runs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dump_valid = 1'b0;
    case (state_q)
      DUMP_IDLE: begin
        idx_d = '0;
        if (dump_req) begin
          state_d = DUMP_STREAM;
        end
      end
      DUMP_STREAM: begin
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (idx_q == REG_IDX_W'(REG_FILE_SIZE - 1)) begin
            state_d = DUMP_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DUMP_DONE: begin
        state_d = DUMP_IDLE;
      end
      default: begin
        state_d = DUMP_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DUMP_IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_q | wb_err;
    end
  end

  assign dump_idx = idx_q;
  assign dump_val = regs_q[idx_q];
  assign err      = err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus random traffic,
// all compared against an array-based behavioural model of the register file.
module tb_reg_file_sb;
  import RegMap::*;

  logic        clk = 1'b0;
  logic        reset;
  reg_id_t     rd_a_id, rd_b_id, rsv_id, wb_id;
  reg_val_t    rd_a_val, rd_b_val, wb_val, dump_val;
  logic        rd_a_ready, rd_b_ready, rsv_valid, rsv_ready, wb_valid, flush;
  logic        dump_req, dump_valid, dump_ready, err;
  logic [63:0] pc_val, imm_val;
  logic [4:0]  dump_idx;

  int checks   = 0;
  int failures = 0;

  reg_val_t m_val [20];
  bit       m_busy [20];
  bit       m_err;
  int       m_phase;    // 0 idle, 1 streaming, 2 done
  int       m_idx;
  int       dut_beats;
  reg_val_t seen8;

  reg_file_sb #(.BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset),
    .rd_a_id(rd_a_id), .rd_b_id(rd_b_id),
    .rd_a_val(rd_a_val), .rd_b_val(rd_b_val),
    .rd_a_ready(rd_a_ready), .rd_b_ready(rd_b_ready),
    .pc_val(pc_val), .imm_val(imm_val),
    .rsv_valid(rsv_valid), .rsv_id(rsv_id), .rsv_ready(rsv_ready),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_val(wb_val),
    .flush(flush),
    .dump_req(dump_req), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_val(dump_val),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [69:0] got, input logic [69:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_real(input reg_id_t id);
    return int'(id) < 20;
  endfunction

  function automatic reg_val_t exp_val(input reg_id_t id);
    reg_val_t r;
    r = '0;
    if (is_real(id)) begin
      if (wb_valid && wb_id == id) r = wb_val;
      else r = m_val[int'(id)];
    end else if (id == rv8) r.val = 64'd8;
    else if (id == rip) r.val = pc_val;
    else if (id == rimm) r.val = imm_val;
    return r;
  endfunction

  function automatic bit exp_rdy(input reg_id_t id);
    if (!is_real(id)) return 1'b1;
    if (wb_valid && wb_id == id) return 1'b1;
    return !m_busy[int'(id)];
  endfunction

  function automatic bit exp_rsv_ready();
    if (!is_real(rsv_id)) return 1'b1;
    if (!m_busy[int'(rsv_id)]) return 1'b1;
    return wb_valid && (wb_id == rsv_id);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 20; i++) begin
      m_val[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_err   = 1'b0;
    m_phase = 0;
    m_idx   = 0;
  endtask

  task automatic model_edge();
    bit rsv_ok;
    bit wb_ok;
    rsv_ok = exp_rsv_ready();
    wb_ok  = wb_valid && is_real(wb_id) && m_busy[int'(wb_id)];
    if (wb_valid && !wb_ok) m_err = 1'b1;
    if (wb_ok) begin
      m_val[int'(wb_id)]  = wb_val;
      m_busy[int'(wb_id)] = 1'b0;
    end
    if (rsv_valid && rsv_ok && is_real(rsv_id)) m_busy[int'(rsv_id)] = 1'b1;
    if (flush) for (int i = 0; i < 20; i++) m_busy[i] = 1'b0;
    case (m_phase)
      0: if (dump_req) m_phase = 1;
      1: if (dump_ready) begin
           if (m_idx == 19) begin m_phase = 2; m_idx = 0; end
           else m_idx++;
         end
      default: m_phase = 0;
    endcase
  endtask

  // Inputs are set just after a falling edge; outputs are checked 1 time
  // unit later, then the model follows the DUT across the rising edge.
  task automatic step();
    #1;
    check_eq("rd_a_val", rd_a_val, exp_val(rd_a_id));
    check_eq("rd_a_ready", rd_a_ready, exp_rdy(rd_a_id));
    check_eq("rd_b_val", rd_b_val, exp_val(rd_b_id));
    check_eq("rd_b_ready", rd_b_ready, exp_rdy(rd_b_id));
    check_eq("rsv_ready", rsv_ready, exp_rsv_ready());
    check_eq("err", err, m_err);
    check_eq("dump_valid", dump_valid, (m_phase == 1));
    if (m_phase == 1) begin
      check_eq("dump_idx", dump_idx, m_idx);
      check_eq("dump_val", dump_val, m_val[m_idx]);
    end
    if (dump_valid && dump_ready) begin
      dut_beats++;
      if (dump_idx == 5'd8) seen8 = dump_val;
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rsv_valid  = 1'b0; rsv_id   = rnil;
    wb_valid   = 1'b0; wb_id    = rnil; wb_val = '0;
    flush      = 1'b0;
    dump_req   = 1'b0; dump_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    rd_a_id = rcx; rd_b_id = rhc;
    model_reset();
    #1;
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_dump_valid", dump_valid, 1'b0);
    check_eq("rst_dump_idx", dump_idx, 5'd0);
    check_eq("rst_rd_a_val", rd_a_val, 70'd0);
    check_eq("rst_rd_a_ready", rd_a_ready, 1'b1);
    check_eq("rst_rd_b_val", rd_b_val, 70'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic reg_id_t pick_id();
    reg_id_t fakes [6];
    fakes = '{rnil, rsyscall, rv0, rv8, rip, rimm};
    if ($urandom_range(0, 9) < 7) return reg_id_t'($urandom_range(0, 19));
    return fakes[$urandom_range(0, 5)];
  endfunction

  function automatic reg_val_t rand_val();
    reg_val_t r;
    r.flags = 6'($urandom);
    r.val   = {$urandom, $urandom};
    return r;
  endfunction

  initial begin
    pc_val  = 64'h0000_1000_2000_3000;
    imm_val = 64'hFFFF_0000_ABCD_0001;
    do_reset();

    // Basic reads after reset
    rd_a_id = rax; rd_b_id = rv8;
    #1;
    check_eq("rax_val", rd_a_val, 70'd0);
    check_eq("rv8_val", rd_b_val, 70'd8);
    step();

    // Reserve rcx, observe busy, write back with bypass, re-reserve
    rsv_valid = 1'b1; rsv_id = rcx; step();
    idle(); rd_a_id = rcx;
    #1; check_eq("rcx_busy", rd_a_ready, 1'b0);
    step();
    wb_valid = 1'b1; wb_id = rcx; wb_val = 70'h1234;
    #1;
    check_eq("rcx_byp_rdy", rd_a_ready, 1'b1);
    check_eq("rcx_byp_val", rd_a_val, 70'h1234);
    step();
    idle(); rsv_valid = 1'b1; rsv_id = rcx;
    #1; check_eq("rcx_rsv_rdy", rsv_ready, 1'b1);
    step();
    idle(); wb_valid = 1'b1; wb_id = rcx; wb_val = 70'h55; step();

    // WAW stall on rdx
    idle(); rsv_valid = 1'b1; rsv_id = rdx; step();
    #1; check_eq("rdx_waw", rsv_ready, 1'b0);
    step();
    wb_valid = 1'b1; wb_id = rdx; wb_val = 70'h77;
    #1; check_eq("rdx_wb_rsv", rsv_ready, 1'b1);
    step();
    idle(); rd_a_id = rdx;
    #1; check_eq("rdx_busy_again", rd_a_ready, 1'b0);
    step();
    wb_valid = 1'b1; wb_id = rdx; wb_val = 70'h78; step();

    // Illegal write-backs
    idle(); wb_valid = 1'b1; wb_id = rbx; wb_val = 70'hDEAD; step();
    wb_id = rimm; step();
    idle(); rd_a_id = rbx;
    #1;
    check_eq("err_set", err, 1'b1);
    check_eq("rbx_kept", rd_a_val, 70'd0);
    step();
    do_reset();

    // Dump with toggling dump_ready
    rsv_valid = 1'b1; rsv_id = r8; step();
    idle(); wb_valid = 1'b1; wb_id = r8; wb_val = 70'hAA; step();
    idle(); dump_req = 1'b1; dut_beats = 0; seen8 = '0; step();
    dump_req = 1'b0;
    for (int c = 0; c < 80; c++) begin
      dump_ready = (c % 2 == 0);
      step();
      if (m_phase == 0) break;
    end
    dump_ready = 1'b0;
    #1;
    check_eq("dump_beats", dut_beats, 20);
    check_eq("dump_r8", seen8, 70'hAA);
    check_eq("dump_idle", dump_valid, 1'b0);
    step();

    // Flush overrides a same-cycle reservation
    idle(); rsv_valid = 1'b1; rsv_id = rsi; step();
    rsv_id = rdi; step();
    rsv_id = r9; flush = 1'b1; step();
    idle(); rd_a_id = rsi; rd_b_id = rdi; rsv_id = r9;
    #1;
    check_eq("flush_rsi", rd_a_ready, 1'b1);
    check_eq("flush_rdi", rd_b_ready, 1'b1);
    check_eq("flush_r9", rsv_ready, 1'b1);
    step();

    // Reset in the middle of a dump aborts it at once
    idle(); dump_req = 1'b1; step();
    dump_req = 1'b0; dump_ready = 1'b1; step(); step();
    reset = 1'b1;
    #1;
    check_eq("abort_valid", dump_valid, 1'b0);
    check_eq("abort_idx", dump_idx, 5'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) step();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      int busy_q [$];
      idle();
      rd_a_id = pick_id(); rd_b_id = pick_id();
      pc_val = {$urandom, $urandom}; imm_val = {$urandom, $urandom};
      rsv_valid = ($urandom_range(0, 2) != 0); rsv_id = pick_id();
      for (int i = 0; i < 20; i++) if (m_busy[i]) busy_q.push_back(i);
      wb_valid = ($urandom_range(0, 1) == 1);
      if (busy_q.size() > 0 && $urandom_range(0, 15) != 0)
        wb_id = reg_id_t'(busy_q[$urandom_range(0, busy_q.size() - 1)]);
      else
        wb_id = pick_id();
      if ($urandom_range(0, 3) == 0) rd_a_id = wb_id;
      wb_val = rand_val();
      flush = ($urandom_range(0, 15) == 0);
      dump_req = ($urandom_range(0, 9) == 0);
      dump_ready = ($urandom_range(0, 1) == 1);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
